// File: rtl/crypt_pkg.sv
// Shared cipher constants and bit permutations used by the encryption and decryption stages.
package crypt_pkg;

    localparam int N = 8;

    localparam logic [N-1:0] K1      = 8'h3E;
    localparam logic [N-1:0] K2      = 8'h49;
    localparam logic [N-1:0] K3      = 8'h7E;
    localparam logic [N-1:0] KEY_ALL = K1 ^ K2 ^ K3;

    // Encryption-side scramble; inv_perm below undoes it bit for bit.
    function automatic logic [N-1:0] fwd_perm(input logic [N-1:0] p);
        return {p[0], p[5], p[2], p[6], p[7], p[4], p[3], p[1]};
    endfunction

    function automatic logic [N-1:0] inv_perm(input logic [N-1:0] s);
        return {s[3], s[4], s[6], s[2], s[1], s[5], s[0], s[7]};
    endfunction

endpackage

// File: rtl/dec_fifo.sv
// Register-based output FIFO for the decryption block; a push on a full FIFO succeeds only
// when a pop happens in the same cycle, otherwise it is silently dropped.
module dec_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [N-1:0]             wdata,
    output logic [N-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_pop_s;
    logic          do_push_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && ((count_q != CNT_MAX) || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers; storage is cleared too so the head reads zero out of reset.
    always_ff @(posedge clock) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);

endmodule

// File: rtl/decryption.sv
// Two-stage decryption pipeline (key XOR, inverse permutation) feeding an output FIFO.
// Optional feature macro DEC_STATS_EN adds a 16-bit wrapping pop counter on port cnt.
module decryption
    import crypt_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] din,
    input  logic         v_in,
    output logic [N-1:0] dout,
    output logic         dv,
    input  logic         rdy,
    output logic         full,
    output logic         ovf
`ifdef DEC_STATS_EN
    ,
    output logic [15:0]  cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic         s1_valid_q, s1_valid_d;
    logic [N-1:0] s1_data_q, s1_data_d;
    logic         ovf_q, ovf_d;
    logic [N-1:0] plain_s;
    logic [N-1:0] rdata_s;
    logic [AW:0]  count_s;
    logic         full_s;
    logic         empty_s;
    logic         pop_ok_s;

    // Stage 2 is combinational: the inverse permutation goes straight into the FIFO write port.
    assign plain_s  = inv_perm(s1_data_q);
    assign pop_ok_s = rdy && !empty_s;

    dec_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (s1_valid_q),
        .pop   (rdy),
        .wdata (plain_s),
        .rdata (rdata_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Stage-1 accept and sticky overflow next-state.
    always_comb begin
        s1_valid_d = en && v_in;
        if (s1_valid_d) begin
            s1_data_d = din ^ KEY_ALL;
        end else begin
            s1_data_d = s1_data_q;
        end
        if (s1_valid_q && full_s && !pop_ok_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Stage-1 and overflow registers.
    always_ff @(posedge clock) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign dout = rdata_s;
    assign dv   = (count_s != '0);
    assign full = full_s;
    assign ovf  = ovf_q;

`ifdef DEC_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Pop counter next-state; wraps naturally at 16 bits.
    always_comb begin
        if (pop_ok_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pop counter register.
    always_ff @(posedge clock) begin
        if (!rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: doc/decryption.md
DECRYPTION -- requirements
Module: decryption

Interface
REQ-001 Parameter N, default 8: data byte width.
REQ-002 Parameter DEPTH, default 4: output FIFO entries, power of two, at least 2.
REQ-003 clock  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled only on posedge clock.
REQ-005 en  input  1  block enable; when low, no input byte is accepted.
REQ-006 din  input  N  cipher byte from the upstream encryption stage.
REQ-007 v_in  input  1  din valid, a single-cycle strobe per byte, no backpressure.
REQ-008 dout  output  N  plaintext byte at the FIFO head.
REQ-009 dv  output  1  dout valid; high whenever the FIFO is non-empty.
REQ-010 rdy  input  1  downstream ready; a pop occurs on any cycle with dv and rdy both high.
REQ-011 full  output  1  FIFO count equals DEPTH.
REQ-012 ovf  output  1  sticky overflow flag; set when a byte is dropped.

Function
REQ-013 Accept: a byte is accepted on any cycle t where en=1 and v_in=1; din is registered into stage 1 as din^KEY_ALL, where KEY_ALL = K1^K2^K3 = 8'h09.
REQ-014 Stage 2, at cycle t+1: inverse permutation of stage 1 value s, giving plain = {s[3],s[4],s[6],s[2],s[1],s[5],s[0],s[7]} (bit 7 down to bit 0); the result is written to the FIFO.
REQ-015 Latency: the accepted byte appears at the FIFO head with dv=1 at cycle t+2 when the FIFO was empty; the block sustains one byte per cycle.
REQ-016 Stage valid bits advance every cycle; stage 1 and stage 2 never stall.
REQ-017 FIFO write with count<DEPTH: store the byte and increment count.
REQ-018 FIFO write with count==DEPTH and no pop in the same cycle: drop the byte, set ovf=1, leave count unchanged.
REQ-019 Simultaneous write and pop: both take effect, count is unchanged, and the write succeeds even when the FIFO is full.
REQ-020 Pop on an empty FIFO: no effect.
REQ-021 Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.
REQ-022 dout holds its value while dv=1 and rdy=0.
REQ-023 Output order equals acceptance order.
REQ-024 en is checked only at accept; bytes already in stages 1 and 2 complete regardless of en.

Reset
REQ-025 With rst=0 at a posedge, the following clear: stage valids, stage data, FIFO pointers and count; dout=0, dv=0, full=0, ovf=0.
REQ-026 Reset mid-operation discards all in-flight and buffered bytes; nothing emerges afterwards.
REQ-027 ovf clears only on reset.

Configuration
REQ-028 Macro DEC_STATS_EN; when defined, adds output port cnt (16 bits), reset to 0, incremented on each pop, wrapping from 16'hFFFF to 0.
REQ-029 When DEC_STATS_EN is undefined, the cnt port and its logic are absent, and all other behaviour is identical.

Structure
REQ-030 Shared package crypt_pkg holds N, K1=8'h3E, K2=8'h49, K3=8'h7E, KEY_ALL, and the forward and inverse permutation functions; the encryption and decryption blocks share this package.
REQ-031 Sub-module dec_fifo (parameters N and DEPTH; ports push, pop, wdata, rdata, count, full, empty) holds the buffer; the top level holds stages 1 and 2 and ovf.

Verification
REQ-032 Directed scenario: din=8'h89 with v_in=1 and en=1 at cycle t, rdy=1 -> dout=8'h01 with dv=1 at cycle t+2, popped at cycle t+2.
REQ-033 Directed scenario: the sequence 8'hF6, 8'h01, 8'h09 on consecutive cycles, rdy=1 -> dout=8'hFF, 8'h80, 8'h00 on cycles t+2, t+3, t+4.
REQ-034 Directed scenario: rdy=0 with 5 bytes accepted -> full=1 after the 4th write, the 5th byte is dropped, and ovf=1; raising rdy yields exactly the first 4 bytes, in order.
REQ-035 Directed scenario: FIFO full with rdy=1 and a write in the same cycle -> no drop, ovf stays 0, count stays 4.
REQ-036 Directed scenario: en=0 with v_in pulses -> dv stays 0; rst=0 pulse with 3 bytes buffered -> next cycle dv=0, full=0, ovf=0, and no stale output.
REQ-037 Directed scenario: DEC_STATS_EN defined, 16'hFFFF pops preloaded, then 2 more pops -> cnt goes 16'hFFFF, 16'h0000, 16'h0001.
